data_mem_responder: RTL and testbench

- Memory-side responder for the multicycle processor's load/store traffic.
- Accepts one word read or write request per handshake from the control/datapath initiator.
- Services the request from an internal word array after a programmable number of wait states, then returns a response that is held until the initiator accepts it.
- Sits between the control FSM's memory-access states and the data storage, and replaces the zero-latency data memory.

---
 rtl/data_mem_responder.sv | 195 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Memory-side responder for the multicycle processor's load/store traffic.
// Accepts one word read/write per request handshake, services it from an
// internal word array after WAIT_CYCLES wait states, and holds the response
// until the initiator accepts it.
//
// Optional feature macro: MEM_ACCESS_CHECK_EN
//   defined   : misaligned or out-of-range accesses are rejected (rsp_err = 1)
//   undefined : low/high address bits ignored, index wraps modulo DEPTH
//
// Parameters:
//   DEPTH        number of 32-bit words (power of two, >= 2)
//   WAIT_CYCLES  wait states between accept and response (0..15)
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   req_valid  request present          req_ready  responder can accept
//   req_we     1 = write, 0 = read      req_addr   byte address
//   req_wdata  write data
//   rsp_valid  response available       rsp_ready  initiator consumes response
//   rsp_rdata  read data (0 for writes / errors)
//   rsp_err    access rejected
module data_mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_q, state_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;
  logic              cap_we_q, cap_we_nx;
  logic [IDX_W-1:0]  cap_idx_q, cap_idx_nx;
  logic [DATA_W-1:0] cap_wdata_q, cap_wdata_nx;
  logic              cap_err_q, cap_err_nx;

  logic              req_ready_nx;
  logic              rsp_valid_nx;
  logic [DATA_W-1:0] rsp_rdata_nx;
  logic              rsp_err_nx;

  logic              access_c;
  logic              acc_we_c;
  logic [IDX_W-1:0]  acc_idx_c;
  logic [DATA_W-1:0] acc_wdata_c;
  logic              acc_err_c;
  logic              mem_we_c;

  logic [IDX_W-1:0]  req_idx_c;
  logic              req_err_c;

  logic [DATA_W-1:0] mem [DEPTH];

  assign req_idx_c = req_addr[IDX_W+1:2];

`ifdef MEM_ACCESS_CHECK_EN
  // Reject misaligned addresses and word indices beyond the array.
  assign req_err_c = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH));
`else
  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_c;
  assign unused_addr_c = ^{req_addr[31:IDX_W+2], req_addr[1:0]};
  assign req_err_c     = 1'b0;
`endif

  // Next-state, capture and response logic.
  always_comb begin
    state_nx     = state_q;
    cnt_nx       = cnt_q;
    cap_we_nx    = cap_we_q;
    cap_idx_nx   = cap_idx_q;
    cap_wdata_nx = cap_wdata_q;
    cap_err_nx   = cap_err_q;
    req_ready_nx = req_ready;
    rsp_valid_nx = rsp_valid;
    rsp_rdata_nx = rsp_rdata;
    rsp_err_nx   = rsp_err;
    access_c     = 1'b0;
    acc_we_c     = cap_we_q;
    acc_idx_c    = cap_idx_q;
    acc_wdata_c  = cap_wdata_q;
    acc_err_c    = cap_err_q;
    mem_we_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cap_we_nx    = req_we;
          cap_idx_nx   = req_idx_c;
          cap_wdata_nx = req_wdata;
          cap_err_nx   = req_err_c;
          req_ready_nx = 1'b0;
          if (WAIT_CYCLES == 0) begin
            // Zero wait states: access straight from the live request.
            access_c    = 1'b1;
            acc_we_c    = req_we;
            acc_idx_c   = req_idx_c;
            acc_wdata_c = req_wdata;
            acc_err_c   = req_err_c;
            state_nx    = RESP;
          end else begin
            cnt_nx   = CNT_W'(WAIT_CYCLES - 1);
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          access_c = 1'b1;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nx = 1'b0;
          rsp_rdata_nx = '0;
          rsp_err_nx   = 1'b0;
          req_ready_nx = 1'b1;
          state_nx     = IDLE;
        end
      end
      default: begin
        state_nx     = IDLE;
        req_ready_nx = 1'b1;
        rsp_valid_nx = 1'b0;
        rsp_rdata_nx = '0;
        rsp_err_nx   = 1'b0;
      end
    endcase

    // The access itself happens on the edge that enters RESP.
    if (access_c) begin
      rsp_valid_nx = 1'b1;
      rsp_err_nx   = acc_err_c;
      rsp_rdata_nx = (acc_we_c || acc_err_c) ? '0 : mem[acc_idx_c];
      mem_we_c     = acc_we_c && !acc_err_c;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cap_we_q    <= 1'b0;
      cap_idx_q   <= '0;
      cap_wdata_q <= '0;
      cap_err_q   <= 1'b0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      state_q     <= state_nx;
      cnt_q       <= cnt_nx;
      cap_we_q    <= cap_we_nx;
      cap_idx_q   <= cap_idx_nx;
      cap_wdata_q <= cap_wdata_nx;
      cap_err_q   <= cap_err_nx;
      req_ready   <= req_ready_nx;
      rsp_valid   <= rsp_valid_nx;
      rsp_rdata   <= rsp_rdata_nx;
      rsp_err     <= rsp_err_nx;
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[acc_idx_c] <= acc_wdata_c;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder. Instance 0 uses WAIT_CYCLES = 0,
// instance 1 uses WAIT_CYCLES = 2; both use DEPTH = 256.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 256;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_rdata [2];
  logic [1:0]  rsp_err;

  int checks;
  int errors;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_we(req_we[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_we(req_we[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance s; lat counts edges from the accept edge
  // (inclusive) to the edge that raised rsp_valid.
  task automatic do_req(input int s, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
    int w;
    req_valid[s] = 1'b1;
    req_we[s]    = we;
    req_addr[s]  = addr;
    req_wdata[s] = wd;
    w = 0;
    while (req_ready[s] !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    checks++;
    if (w >= 20) begin
      errors++;
      $display("FAIL accept_timeout dut%0d: req_ready=%b required 1", s, req_ready[s]);
    end
    step();
    req_valid[s] = 1'b0;
    req_addr[s]  = 32'hFFFF_FFFC;
    req_wdata[s] = 32'h0BAD_0BAD;
    lat = 1;
    while (rsp_valid[s] !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    rd = rsp_rdata[s];
    er = rsp_err[s];
    rsp_ready[s] = 1'b1;
    step();
    rsp_ready[s] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (req_ready[s] !== 1'b1) begin errors++; $display("FAIL reset_req_ready dut%0d: got %b want 1", s, req_ready[s]); end
      checks++;
      if (rsp_valid[s] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid dut%0d: got %b want 0", s, rsp_valid[s]); end
      checks++;
      if (rsp_rdata[s] !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata dut%0d: got %h want 0", s, rsp_rdata[s]); end
      checks++;
      if (rsp_err[s] !== 1'b0) begin errors++; $display("FAIL reset_rsp_err dut%0d: got %b want 0", s, rsp_err[s]); end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    logic er;
    int lat;
    do_req(1, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL wr_latency: got %0d want 3", lat); end
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL wr_rsp: rdata=%h err=%b want 0/0", rd, er); end
    do_req(1, 1'b0, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL rd_latency: got %0d want 3", lat); end
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", er); end
  endtask

  task automatic test_backpressure();
    int w;
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_addr[1]  = 32'h10;
    step();
    req_valid[1] = 1'b0;
    w = 0;
    while (rsp_valid[1] !== 1'b1 && w < 20) begin step(); w++; end
    checks++;
    if (w != 2) begin errors++; $display("FAIL bp_latency: waited %0d more edges want 2", w); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'hDEAD_BEEF || req_ready[1] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: valid=%b rdata=%h ready=%b want 1/deadbeef/0",
                 i, rsp_valid[1], rsp_rdata[1], req_ready[1]);
      end
    end
    rsp_ready[1] = 1'b1;
    step();
    rsp_ready[1] = 1'b0;
    checks++;
    if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'h0) begin
      errors++;
      $display("FAIL bp_release: ready=%b valid=%b rdata=%h want 1/0/0",
               req_ready[1], rsp_valid[1], rsp_rdata[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    logic [31:0] rd;
    logic er;
    int lat;
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_addr[0]  = 32'(i * 4);
      req_wdata[0] = 32'(100 + i);
      acc = req_ready[0];
      checks++;
      if (acc !== ((i % 2) == 0)) begin
        errors++;
        $display("FAIL b2b_accept cycle %0d: req_ready=%b want %b", i, acc, (i % 2) == 0);
      end
      step();
      if ((i % 2) == 0) begin
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h0) begin
          errors++;
          $display("FAIL b2b_rsp cycle %0d: valid=%b rdata=%h want 1/0", i, rsp_valid[0], rsp_rdata[0]);
        end
      end
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b0;
    do_req(0, 1'b0, 32'h8, 32'h0, rd, er, lat);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL w0_latency: got %0d want 1", lat); end
    checks++;
    if (rd !== 32'd102) begin errors++; $display("FAIL b2b_word2: got %0d want 102", rd); end
    do_req(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'd104) begin errors++; $display("FAIL b2b_word4: got %0d want 104", rd); end
  endtask

  task automatic test_access_check();
    logic [31:0] rd;
    logic er;
    int lat;
    logic        exp_err;
    logic [31:0] exp_w4;
    logic [31:0] exp_w0;
`ifdef MEM_ACCESS_CHECK_EN
    exp_err = 1'b1;
    exp_w4  = 32'hDEAD_BEEF;
    exp_w0  = 32'hA5A5_A5A5;
`else
    exp_err = 1'b0;
    exp_w4  = 32'h1111_1111;
    exp_w0  = 32'h2222_2222;
`endif
    do_req(1, 1'b1, 32'h12, 32'h1111_1111, rd, er, lat);
    checks++;
    if (er !== exp_err || rd !== 32'h0 || lat != 3) begin
      errors++;
      $display("FAIL misaligned_wr: err=%b rdata=%h lat=%0d want %b/0/3", er, rd, lat, exp_err);
    end
    do_req(1, 1'b0, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== exp_w4) begin errors++; $display("FAIL misaligned_mem: got %h want %h", rd, exp_w4); end
    do_req(1, 1'b1, 32'h0, 32'hA5A5_A5A5, rd, er, lat);
    do_req(1, 1'b1, 32'(DEPTH * 4), 32'h2222_2222, rd, er, lat);
    checks++;
    if (er !== exp_err || rd !== 32'h0) begin
      errors++;
      $display("FAIL range_wr: err=%b rdata=%h want %b/0", er, rd, exp_err);
    end
    do_req(1, 1'b0, 32'h0, 32'h0, rd, er, lat);
    checks++;
    if (rd !== exp_w0 || er !== 1'b0) begin
      errors++;
      $display("FAIL range_mem: got %h err=%b want %h/0", rd, er, exp_w0);
    end
`ifdef MEM_ACCESS_CHECK_EN
    do_req(1, 1'b0, 32'h12, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_rd: rdata=%h err=%b want 0/1", rd, er);
    end
`endif
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd;
    logic er;
    int lat;
    do_req(1, 1'b1, 32'h20, 32'h33, rd, er, lat);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_addr[1]  = 32'h20;
    req_wdata[1] = 32'h55;
    step();
    req_valid[1] = 1'b0;
    checks++;
    if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b want 0", req_ready[1]); end
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL async_ready: got %b want 1", req_ready[1]); end
    step();
    step();
    reset = 1'b1;
    do_req(1, 1'b0, 32'h20, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h33) begin errors++; $display("FAIL mid_write_dropped: got %h want 33", rd); end
    // Reset while holding a response must clear outputs without a clock edge.
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_addr[1]  = 32'h20;
    step();
    req_valid[1] = 1'b0;
    step();
    step();
    checks++;
    if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'h33) begin
      errors++;
      $display("FAIL resp_before_reset: valid=%b rdata=%h want 1/33", rsp_valid[1], rsp_rdata[1]);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'h0 || req_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL async_clear: valid=%b rdata=%h ready=%b want 0/0/1",
               rsp_valid[1], rsp_rdata[1], req_ready[1]);
    end
    step();
    reset = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    rsp_ready = '0;
    for (int s = 0; s < 2; s++) begin
      req_addr[s]  = '0;
      req_wdata[s] = '0;
    end
    test_reset();
    test_write_read();
    test_backpressure();
    test_back_to_back();
    test_access_check();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
